// File: rtl/alarm_setter.sv
// Alarm-time writer: key edge detection, VIEW/SET_H/SET_M editor, BCD display and seconds-of-day output.
// Define ALARM_SETTER_TIMEOUT_EN to abort uncommitted edits after TIMEOUT_S idle seconds.
module alarm_setter #(
  parameter int TIMEOUT_S = 10,
  parameter int RST_HOUR  = 7,
  parameter int RST_MIN   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic        key_en,
  output logic [20:0] count_alarm,
  output logic        alarm_on,
  output logic [1:0]  setting,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd
);

  typedef enum logic [1:0] {VIEW = 2'b00, SET_H = 2'b01, SET_M = 2'b10} state_t;

  localparam logic [7:0]  RST_HOUR_BCD = {4'(RST_HOUR / 10), 4'(RST_HOUR % 10)};
  localparam logic [7:0]  RST_MIN_BCD  = {4'(RST_MIN / 10), 4'(RST_MIN % 10)};
  localparam logic [20:0] DISABLED     = 21'h1FFFFF;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)              r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00)            r = max;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [20:0] bcd_seconds(input logic [7:0] h, input logic [7:0] m);
    logic [20:0] hb, mb;
    hb = 21'(h[7:4]) * 21'd10 + 21'(h[3:0]);
    mb = 21'(m[7:4]) * 21'd10 + 21'(m[3:0]);
    return hb * 21'd3600 + mb * 21'd60;
  endfunction

  logic [3:0]  key_q, key_d, key_prev_q, key_prev_d;
  state_t      state_q, state_d;
  logic        alarm_on_q, alarm_on_d;
  logic [7:0]  com_h_q, com_h_d, com_m_q, com_m_d;
  logic [7:0]  sh_h_q, sh_h_d, sh_m_q, sh_m_d;
  logic [20:0] count_q, count_d;
  logic        ev_mode, ev_inc, ev_dec, ev_en, step_up, step_dn;

`ifdef ALARM_SETTER_TIMEOUT_EN
  logic [5:0]  idle_q, idle_d;
`else
  logic        unused_tick_1hz;
  assign unused_tick_1hz = tick_1hz;
`endif

  // Events come from the registered sample against the one before it, so a held key fires once.
  assign ev_mode = key_q[0] & ~key_prev_q[0];
  assign ev_inc  = key_q[1] & ~key_prev_q[1];
  assign ev_dec  = key_q[2] & ~key_prev_q[2];
  assign ev_en   = key_q[3] & ~key_prev_q[3];
  assign step_up = ev_inc & ~ev_dec;
  assign step_dn = ev_dec & ~ev_inc;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    key_d      = {key_en, key_dec, key_inc, key_mode};
    key_prev_d = key_q;
    state_d    = state_q;
    alarm_on_d = alarm_on_q;
    com_h_d    = com_h_q;
    com_m_d    = com_m_q;
    sh_h_d     = sh_h_q;
    sh_m_d     = sh_m_q;

    unique case (state_q)
      VIEW: begin
        if (ev_mode) begin
          sh_h_d  = com_h_q;
          sh_m_d  = com_m_q;
          state_d = SET_H;
        end
        if (ev_en) alarm_on_d = ~alarm_on_q;
      end
      SET_H: begin
        if (ev_mode)      state_d = SET_M;
        else if (step_up) sh_h_d  = bcd_inc(sh_h_q, 8'h23);
        else if (step_dn) sh_h_d  = bcd_dec(sh_h_q, 8'h23);
      end
      SET_M: begin
        if (ev_mode) begin
          com_h_d = sh_h_q;
          com_m_d = sh_m_q;
          state_d = VIEW;
        end
        else if (step_up) sh_m_d = bcd_inc(sh_m_q, 8'h59);
        else if (step_dn) sh_m_d = bcd_dec(sh_m_q, 8'h59);
      end
      default: state_d = VIEW;
    endcase

`ifdef ALARM_SETTER_TIMEOUT_EN
    // Any key event clears the counter, so a mode event always beats the timeout.
    idle_d = idle_q;
    if (state_q == VIEW || ev_mode || ev_inc || ev_dec || ev_en) idle_d = '0;
    else if (tick_1hz)                                          idle_d = idle_q + 6'd1;
    if (state_q != VIEW && idle_d == 6'(TIMEOUT_S)) begin
      state_d = VIEW;
      sh_h_d  = com_h_q;
      sh_m_d  = com_m_q;
    end
`endif

    count_d = alarm_on_q ? bcd_seconds(com_h_q, com_m_q) : DISABLED;
  end

  // NOTE: state is updated with non-blocking assignments; rst is only seen on a rising clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      key_prev_q <= '0;
      state_q    <= VIEW;
      alarm_on_q <= 1'b0;
      com_h_q    <= RST_HOUR_BCD;
      com_m_q    <= RST_MIN_BCD;
      sh_h_q     <= RST_HOUR_BCD;
      sh_m_q     <= RST_MIN_BCD;
      count_q    <= DISABLED;
`ifdef ALARM_SETTER_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      key_q      <= key_d;
      key_prev_q <= key_prev_d;
      state_q    <= state_d;
      alarm_on_q <= alarm_on_d;
      com_h_q    <= com_h_d;
      com_m_q    <= com_m_d;
      sh_h_q     <= sh_h_d;
      sh_m_q     <= sh_m_d;
      count_q    <= count_d;
`ifdef ALARM_SETTER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign count_alarm = count_q;
  assign alarm_on    = alarm_on_q;
  assign setting     = state_q;
  assign hour_bcd    = (state_q == VIEW) ? com_h_q : sh_h_q;
  assign min_bcd     = (state_q == VIEW) ? com_m_q : sh_m_q;

endmodule

// File: tb/tb_alarm_setter.sv
// Scoreboard bench for alarm_setter: expectations are queued with a due cycle when keys are
// driven and compared on the falling edge of that cycle.
module tb_alarm_setter;

  typedef enum int {SEL_SETTING, SEL_ALARM_ON, SEL_COUNT, SEL_HOUR, SEL_MIN} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [20:0] exp;
    int          due;
  } sb_t;

  localparam logic [3:0] KM = 4'b0001;
  localparam logic [3:0] KI = 4'b0010;
  localparam logic [3:0] KD = 4'b0100;
  localparam logic [3:0] KE = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [3:0]  keys = 4'b0000;
  logic [20:0] count_alarm;
  logic        alarm_on;
  logic [1:0]  setting;
  logic [7:0]  hour_bcd;
  logic [7:0]  min_bcd;

  alarm_setter dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .key_mode   (keys[0]),
    .key_inc    (keys[1]),
    .key_dec    (keys[2]),
    .key_en     (keys[3]),
    .count_alarm(count_alarm),
    .alarm_on   (alarm_on),
    .setting    (setting),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  t_ev  = 0;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [20:0] observe(input sel_t s);
    logic [20:0] v;
    case (s)
      SEL_SETTING:  v = 21'(setting);
      SEL_ALARM_ON: v = 21'(alarm_on);
      SEL_COUNT:    v = count_alarm;
      SEL_HOUR:     v = 21'(hour_bcd);
      default:      v = 21'(min_bcd);
    endcase
    return v;
  endfunction

  function automatic logic [20:0] to_bcd(input int v);
    return 21'({4'(v / 10), 4'(v % 10)});
  endfunction

  function automatic logic [20:0] secs(input int h, input int m);
    return 21'(h * 3600 + m * 60);
  endfunction

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic sb_push(input string tag, input sel_t sel, input logic [20:0] exp, input int lat);
    sb_q.push_back('{tag: tag, sel: sel, exp: exp, due: t_ev + lat});
  endtask

  task automatic key_down(input logic [3:0] m);
    @(negedge clk);
    keys = m;
    t_ev = cyc;
  endtask

  task automatic key_up();
    @(negedge clk);
    keys = 4'b0000;
  endtask

  task automatic press(input logic [3:0] m);
    key_down(m);
    key_up();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst  = 1'b1;
    keys = 4'b0000;
    t_ev = cyc;
    sb_push({tag, "_setting"},  SEL_SETTING,  21'd0,        1);
    sb_push({tag, "_alarm_on"}, SEL_ALARM_ON, 21'd0,        1);
    sb_push({tag, "_count"},    SEL_COUNT,    21'h1FFFFF,   1);
    sb_push({tag, "_hour"},     SEL_HOUR,     to_bcd(7),    1);
    sb_push({tag, "_min"},      SEL_MIN,      to_bcd(0),    1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h;
    do_reset("reset");
    repeat (2) @(negedge clk);

    // Enable, then 07:00 -> 09:59 via mode; inc x2; mode; dec; mode.
    press(KE);
    sb_push("en_on",        SEL_ALARM_ON, 21'd1,         2);
    sb_push("en_cnt_lag",   SEL_COUNT,    21'h1FFFFF,    2);
    sb_push("en_cnt",       SEL_COUNT,    secs(7, 0),    3);
    press(KM);
    sb_push("enter_seth",   SEL_SETTING,  21'd1,         2);
    sb_push("shadow_hour",  SEL_HOUR,     to_bcd(7),     2);
    press(KI);
    sb_push("inc_08",       SEL_HOUR,     to_bcd(8),     2);
    press(KI);
    sb_push("inc_09",       SEL_HOUR,     to_bcd(9),     2);
    press(KM);
    sb_push("enter_setm",   SEL_SETTING,  21'd2,         2);
    press(KD);
    sb_push("min_dec_wrap", SEL_MIN,      to_bcd(59),    2);
    press(KM);
    sb_push("commit_view",  SEL_SETTING,  21'd0,         2);
    sb_push("commit_hour",  SEL_HOUR,     to_bcd(9),     2);
    sb_push("commit_min",   SEL_MIN,      to_bcd(59),    2);
    sb_push("commit_alarm", SEL_ALARM_ON, 21'd1,         2);
    sb_push("commit_lag",   SEL_COUNT,    secs(7, 0),    2);
    sb_push("commit_cnt",   SEL_COUNT,    secs(9, 59),   3);

    // Hour wraps both ways, simultaneous inc+dec, held key.
    press(KM);
    sb_push("reenter_seth", SEL_SETTING,  21'd1,         2);
    h = 9;
    for (int i = 0; i < 10; i++) begin
      press(KD);
      h = (h + 23) % 24;
      sb_push($sformatf("hour_dec_%0d", i), SEL_HOUR, to_bcd(h), 2);
    end
    press(KI);
    h = (h + 1) % 24;
    sb_push("hour_inc_wrap", SEL_HOUR,    to_bcd(h),     2);
    press(KI | KD);
    sb_push("inc_dec_both", SEL_HOUR,     to_bcd(h),     2);
    sb_push("inc_dec_state", SEL_SETTING, 21'd1,         2);
    key_down(KI);
    h = (h + 1) % 24;
    sb_push("hold_first",   SEL_HOUR,     to_bcd(h),     2);
    sb_push("hold_mid",     SEL_HOUR,     to_bcd(h),     50);
    repeat (100) @(negedge clk);
    keys = 4'b0000;
    t_ev = cyc;
    sb_push("hold_once",    SEL_HOUR,     to_bcd(h),     2);
    repeat (2) @(negedge clk);

    // Mode wins over inc; en ignored while setting; minute wraps.
    press(KM | KI);
    sb_push("mode_inc_state", SEL_SETTING, 21'd2,        2);
    sb_push("mode_inc_hour",  SEL_HOUR,    to_bcd(h),    2);
    press(KE);
    sb_push("en_in_set",    SEL_ALARM_ON, 21'd1,         2);
    press(KI);
    sb_push("min_inc_wrap", SEL_MIN,      to_bcd(0),     2);
    press(KD);
    sb_push("min_dec_wrap2", SEL_MIN,     to_bcd(59),    2);
    press(KM);
    sb_push("commit2_view", SEL_SETTING,  21'd0,         2);
    sb_push("commit2_lag",  SEL_COUNT,    secs(9, 59),   2);
    sb_push("commit2_cnt",  SEL_COUNT,    secs(1, 59),   3);

    // Disable and re-enable.
    press(KE);
    sb_push("en_off",       SEL_ALARM_ON, 21'd0,         2);
    sb_push("en_off_cnt",   SEL_COUNT,    21'h1FFFFF,    3);
    press(KE);
    sb_push("en_on2",       SEL_ALARM_ON, 21'd1,         2);
    sb_push("en_on2_cnt",   SEL_COUNT,    secs(1, 59),   3);

    // Idle timeout (or its absence) in SET_H after one edit.
    press(KM);
    sb_push("to_enter",     SEL_SETTING,  21'd1,         2);
    press(KI);
    sb_push("to_edit",      SEL_HOUR,     to_bcd(2),     2);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      tick_1hz = 1'b1;
      t_ev = cyc;
      if (i == 9) sb_push("to_tick9", SEL_SETTING, 21'd1, 1);
      if (i == 10) begin
`ifdef ALARM_SETTER_TIMEOUT_EN
        sb_push("to_view",    SEL_SETTING, 21'd0,        1);
        sb_push("to_hour",    SEL_HOUR,    to_bcd(1),    1);
        sb_push("to_cnt",     SEL_COUNT,   secs(1, 59),  2);
`else
        sb_push("no_to_state", SEL_SETTING, 21'd1,       1);
        sb_push("no_to_hour",  SEL_HOUR,    to_bcd(2),   1);
`endif
      end
      @(negedge clk);
      tick_1hz = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Reset from SET_M with an edited shadow.
`ifdef ALARM_SETTER_TIMEOUT_EN
    press(KM);
    sb_push("rs_seth",      SEL_SETTING,  21'd1,         2);
`endif
    press(KM);
    sb_push("rs_setm",      SEL_SETTING,  21'd2,         2);
    press(KI);
    sb_push("rs_edit",      SEL_MIN,      to_bcd(0),     2);
    repeat (2) @(negedge clk);
    do_reset("rst_in_setm");
    press(KM);
    sb_push("post_rst_seth", SEL_SETTING, 21'd1,         2);
    sb_push("post_rst_hour", SEL_HOUR,    to_bcd(7),     2);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", 21'(sb_q.size()), 21'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
